mem_copy_engine: RTL and testbench

Byte-block copy/fill engine sitting directly upstream of DataRAM, driving its MemRead, MemWrite, Address and DataSrc inputs and consuming DataMemOut. On a Start pulse it moves Length bytes from SrcAddr to DstAddr (COPY), or writes a constant to Length bytes at DstAddr (FILL), one DataRAM access per cycle. It then pulses Done. The core uses it for block moves without spending instruction slots on load/store loops.

---
 rtl/mem_copy_pkg.sv | 19 +
 rtl/mem_copy_engine.sv | 110 +++++++++++
 tb/tb_mem_copy_engine.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/mem_copy_pkg.sv
// Types and default widths shared by the copy/fill engine and the DataRAM bench.
package mem_copy_pkg;

    localparam int DEF_AW = 8;
    localparam int DEF_DW = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_e;

    typedef enum logic {
        COPY = 1'b0,
        FILL = 1'b1
    } mode_e;

endpackage

// File: rtl/mem_copy_engine.sv
// Byte-block copy/fill engine driving DataRAM: one access per cycle, COPY takes 2N+1 cycles, FILL N+1.
// No backpressure; Start is ignored while Busy and the core is expected to stall on Busy.
module mem_copy_engine
    import mem_copy_pkg::*;
#(
    parameter int AW = DEF_AW,
    parameter int DW = DEF_DW
) (
    input  logic          CLK,
    input  logic          Reset,
    input  logic          Start,
    input  logic          Mode,
    input  logic [AW-1:0] SrcAddr,
    input  logic [AW-1:0] DstAddr,
    input  logic [AW-1:0] Length,
    input  logic [DW-1:0] FillValue,
    input  logic [DW-1:0] DataMemIn,
    output logic          MemRead,
    output logic          MemWrite,
    output logic [AW-1:0] Address,
    output logic [DW-1:0] DataSrc,
    output logic          Busy,
    output logic          Done
);

    state_e        state_q, state_d;
    mode_e         mode_q, mode_d;
    logic [AW-1:0] src_q, src_d;
    logic [AW-1:0] dst_q, dst_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] data_q, data_d;

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q <= IDLE;
            mode_q  <= COPY;
            src_q   <= '0;
            dst_q   <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        src_d    = src_q;
        dst_d    = dst_q;
        cnt_d    = cnt_q;
        data_d   = data_q;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        Address  = '0;
        DataSrc  = '0;
        Busy     = (state_q != IDLE);
        Done     = 1'b0;

        case (state_q)
            IDLE: begin
                if (Start) begin
                    mode_d = mode_e'(Mode);
                    src_d  = SrcAddr;
                    dst_d  = DstAddr;
                    cnt_d  = Length;
                    data_d = FillValue;
                    if (Length == '0)
                        state_d = DONE;
                    else if (mode_e'(Mode) == FILL)
                        state_d = WRITE;
                    else
                        state_d = READ;
                end
            end
            READ: begin
                MemRead = 1'b1;
                Address = src_q;
                data_d  = DataMemIn;
                src_d   = src_q + AW'(1);
                state_d = WRITE;
            end
            WRITE: begin
                // Overlap is not corrected: a later READ may see a byte this WRITE just stored.
                MemWrite = 1'b1;
                Address  = dst_q;
                DataSrc  = data_q;
                dst_d    = dst_q + AW'(1);
                cnt_d    = cnt_q - AW'(1);
                if (cnt_q == AW'(1))
                    state_d = DONE;
                else if (mode_q == FILL)
                    state_d = WRITE;
                else
                    state_d = READ;
            end
            DONE: begin
                Done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_mem_copy_engine.sv
// Bench for mem_copy_engine with a behavioural DataRAM and an access-order scoreboard.
module tb_mem_copy_engine;
    import mem_copy_pkg::*;

    logic       CLK = 1'b0;
    logic       Reset, Start, Mode;
    logic [7:0] SrcAddr, DstAddr, Length, FillValue, DataMemIn;
    logic       MemRead, MemWrite, Busy, Done;
    logic [7:0] Address, DataSrc;

    logic [7:0] ram   [256];
    logic [7:0] model [256];

    typedef struct packed {
        logic       wr;
        logic [7:0] addr;
        logic [7:0] dat;
    } acc_t;

    typedef struct {
        logic       mode;
        logic [7:0] src;
        logic [7:0] dst;
        logic [7:0] len;
        logic [7:0] fill;
        logic       poke;
        int         exp_done;
    } vec_t;

    acc_t exp_q[$];
    int   total = 0;
    int   bad = 0;

    always #5 CLK = ~CLK;

    assign DataMemIn = ram[Address];
    always @(posedge CLK) if (MemWrite) ram[Address] <= DataSrc;

    mem_copy_engine #(.AW(8), .DW(8)) dut (
        .CLK(CLK), .Reset(Reset), .Start(Start), .Mode(Mode),
        .SrcAddr(SrcAddr), .DstAddr(DstAddr), .Length(Length), .FillValue(FillValue),
        .DataMemIn(DataMemIn), .MemRead(MemRead), .MemWrite(MemWrite),
        .Address(Address), .DataSrc(DataSrc), .Busy(Busy), .Done(Done)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Checks the current cycle's memory activity against the scoreboard.
    task automatic check_access();
        acc_t act, exp;
        if (MemRead && MemWrite) begin
            total++;
            bad++;
            $display("FAIL rd_wr_overlap: MemRead and MemWrite both high at addr %0h", Address);
        end else if (MemRead || MemWrite) begin
            act = '{wr: MemWrite, addr: Address, dat: (MemWrite ? DataSrc : DataMemIn)};
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL extra_access: got %0h expected none", act);
            end else begin
                exp = exp_q.pop_front();
                chk("access", act, exp);
            end
        end
    endtask

    task automatic check_mem(input string name);
        int nbad = 0;
        for (int i = 0; i < 256; i++)
            if (ram[i] !== model[i]) nbad++;
        chk(name, nbad, 0);
    endtask

    task automatic run_vec(input vec_t v);
        logic [7:0] s, d, dat;
        int k;
        bit seen;
        s = v.src;
        d = v.dst;
        for (int i = 0; i < int'(v.len); i++) begin
            if (v.mode == FILL) begin
                dat = v.fill;
            end else begin
                dat = model[s];
                exp_q.push_back('{wr: 1'b0, addr: s, dat: dat});
                s = s + 8'd1;
            end
            exp_q.push_back('{wr: 1'b1, addr: d, dat: dat});
            model[d] = dat;
            d = d + 8'd1;
        end

        Mode = v.mode; SrcAddr = v.src; DstAddr = v.dst;
        Length = v.len; FillValue = v.fill; Start = 1'b1;
        step();
        Start = 1'b0;
        k = 1;
        chk("busy_rise", Busy, 1);
        seen = 0;
        while (!seen && k <= 600) begin
            check_access();
            if (Done) begin
                seen = 1;
                chk("done_cycle", k, v.exp_done);
                chk("done_idle_bus", {Address, DataSrc}, 0);
            end
            if (v.poke && k == 2) begin
                Start = 1'b1; Mode = ~v.mode; SrcAddr = 8'h00;
                DstAddr = 8'h00; Length = 8'd1; FillValue = 8'hFF;
            end
            if (k == 3) Start = 1'b0;
            if (!seen) begin
                step();
                k++;
            end
        end
        if (!seen) begin
            total++;
            bad++;
            $display("FAIL done_timeout: no Done within %0d cycles", k);
        end
        Start = 1'b0;
        step();
        chk("busy_done_fall", {Busy, Done}, 2'b00);
        chk("queue_empty", exp_q.size(), 0);
        exp_q.delete();
        check_mem("mem_contents");
    endtask

    vec_t vecs[7];

    initial begin
        Reset = 1'b1; Start = 1'b0; Mode = 1'b0;
        SrcAddr = '0; DstAddr = '0; Length = '0; FillValue = '0;
        for (int i = 0; i < 256; i++) begin
            ram[i]   = 8'(i) ^ 8'h5A;
            model[i] = 8'(i) ^ 8'h5A;
        end
        for (int i = 0; i < 4; i++) begin
            ram[8'h10 + i]   = 8'(i + 1);
            model[8'h10 + i] = 8'(i + 1);
        end

        vecs[0] = '{COPY, 8'h10, 8'h40, 8'd4, 8'h00, 1'b0, 9};
        vecs[1] = '{FILL, 8'h00, 8'h20, 8'd3, 8'hA5, 1'b1, 4};
        vecs[2] = '{COPY, 8'h30, 8'h60, 8'd0, 8'h00, 1'b0, 1};
        vecs[3] = '{COPY, 8'hFE, 8'hFF, 8'd3, 8'h00, 1'b0, 7};
        vecs[4] = '{FILL, 8'h00, 8'hFE, 8'd4, 8'h3C, 1'b0, 5};
        vecs[5] = '{COPY, 8'h50, 8'h51, 8'd5, 8'h00, 1'b1, 11};
        vecs[6] = '{FILL, 8'h00, 8'h70, 8'd0, 8'h99, 1'b0, 1};

        step();
        step();
        chk("reset_outputs", {MemRead, MemWrite, Address, DataSrc, Busy, Done}, 0);
        Reset = 1'b0;
        step();

        for (int i = 0; i < 7; i++) run_vec(vecs[i]);

        chk("copy_b0", ram[8'h40], 8'h01);
        chk("copy_b1", ram[8'h41], 8'h02);
        chk("copy_b2", ram[8'h42], 8'h03);
        chk("copy_b3", ram[8'h43], 8'h04);
        chk("fill_b0", ram[8'h20], 8'hA5);
        chk("fill_b2", ram[8'h22], 8'hA5);
        chk("fill_past_end", ram[8'h23], 8'h79);

        // Reset lands in the third cycle of an 8-byte copy: only the first byte may reach memory.
        exp_q.push_back('{wr: 1'b0, addr: 8'h80, dat: model[8'h80]});
        exp_q.push_back('{wr: 1'b1, addr: 8'hC0, dat: model[8'h80]});
        exp_q.push_back('{wr: 1'b0, addr: 8'h81, dat: model[8'h81]});
        model[8'hC0] = model[8'h80];
        Mode = COPY; SrcAddr = 8'h80; DstAddr = 8'hC0; Length = 8'd8; Start = 1'b1;
        step();
        Start = 1'b0;
        check_access();
        step();
        check_access();
        step();
        check_access();
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        chk("abort_outputs", {MemRead, MemWrite, Address, DataSrc, Busy, Done}, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("abort_quiet", {MemRead, MemWrite, Busy}, 0);
        end
        chk("abort_queue", exp_q.size(), 0);
        check_mem("abort_mem");

        run_vec('{FILL, 8'h00, 8'hC4, 8'd2, 8'h5E, 1'b0, 3});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
